// File: rtl/token_stream_sequencer_pkg.sv
// Shared sizing and state encoding for the token stream sequencer.
package token_stream_sequencer_pkg;
  localparam int DEPTH   = 64;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int CNT_W   = ADDR_W + 1;
  localparam int TOKEN_W = 32;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, PRESENT, DONE} seq_state_t;
endpackage

// File: rtl/token_stream_sequencer_if.sv
// Token stream towards the expression evaluator (valid/ready with last marker).
interface token_stream_sequencer_if;
  import token_stream_sequencer_pkg::*;

  logic [TOKEN_W-1:0] tokOut;
  logic               tokValid;
  logic               tokReady;
  logic               tokLast;

  modport master (output tokOut, output tokValid, output tokLast, input tokReady);
  modport slave  (input tokOut, input tokValid, input tokLast, output tokReady);
endinterface

// File: rtl/token_stream_sequencer.sv
// Owns the single-port token RAM: buffers keypad tokens while idle, then
// replays them to the evaluator on enter and clears the keypad afterwards.
module token_stream_sequencer
  import token_stream_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  wEn,
  input  logic [TOKEN_W-1:0]    tokenToWrite,
  input  logic                  enterKey,
  output logic [ADDR_W-1:0]     ramAddr,
  output logic                  ramWe,
  output logic [TOKEN_W-1:0]    ramWData,
  input  logic [TOKEN_W-1:0]    ramRData,
  token_stream_sequencer_if.master tok,
  output logic                  keyPadClear,
  output logic                  busy,
  output logic [CNT_W-1:0]      tokenCount,
  output logic                  overflow,
  output logic                  dropErr
);

  seq_state_t        state;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] rdPtr;
  logic              full;
  logic              wr_ok;

  assign full       = (count == CNT_W'(DEPTH));
  assign wr_ok      = (state == IDLE) && wEn && !full;
  assign busy       = (state != IDLE);
  assign tokenCount = count;

  // RAM port: keypad writes go straight through while idle; ISSUE drives the read address.
  always_comb begin
    ramWe    = wr_ok;
    ramWData = wr_ok ? tokenToWrite : '0;
    ramAddr  = '0;
    if (wr_ok)
      ramAddr = count[ADDR_W-1:0];
    else if (state == ISSUE)
      ramAddr = rdPtr;
  end

  // Sequencer FSM with counters, sticky flags and registered stream outputs.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state        <= IDLE;
      count        <= '0;
      rdPtr        <= '0;
      tok.tokOut   <= '0;
      tok.tokValid <= 1'b0;
      tok.tokLast  <= 1'b0;
      keyPadClear  <= 1'b0;
      overflow     <= 1'b0;
      dropErr      <= 1'b0;
    end else begin
      keyPadClear <= 1'b0;
      if (state != IDLE && wEn)
        dropErr <= 1'b1;
      case (state)
        IDLE: begin
          if (wr_ok)
            count <= count + CNT_W'(1);
          if (wEn && full)
            overflow <= 1'b1;
          // a write in the same cycle as enter counts toward the stream
          if (enterKey) begin
            if (wr_ok || count != '0) begin
              state <= ISSUE;
            end else begin
              state       <= DONE;
              keyPadClear <= 1'b1;
            end
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          tok.tokOut   <= ramRData;
          tok.tokLast  <= ({1'b0, rdPtr} == count - CNT_W'(1));
          tok.tokValid <= 1'b1;
          state        <= PRESENT;
        end
        PRESENT: begin
          if (tok.tokReady) begin
            tok.tokValid <= 1'b0;
            tok.tokLast  <= 1'b0;
            if (tok.tokLast) begin
              state       <= DONE;
              keyPadClear <= 1'b1;
            end else begin
              rdPtr <= rdPtr + ADDR_W'(1);
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          count    <= '0;
          rdPtr    <= '0;
          overflow <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_token_stream_sequencer.sv
// Randomized bench for token_stream_sequencer against a queue-based model.
module tb_token_stream_sequencer;
  import token_stream_sequencer_pkg::*;

  logic               clk = 1'b0;
  logic               resetN;
  logic               wEn;
  logic [TOKEN_W-1:0] tokenToWrite;
  logic               enterKey;
  logic [ADDR_W-1:0]  ramAddr;
  logic               ramWe;
  logic [TOKEN_W-1:0] ramWData;
  logic [TOKEN_W-1:0] ramRData;
  logic               keyPadClear;
  logic               busy;
  logic [CNT_W-1:0]   tokenCount;
  logic               overflow;
  logic               dropErr;

  token_stream_sequencer_if tok_bus();

  token_stream_sequencer dut (
    .clk(clk), .resetN(resetN), .wEn(wEn), .tokenToWrite(tokenToWrite),
    .enterKey(enterKey), .ramAddr(ramAddr), .ramWe(ramWe), .ramWData(ramWData),
    .ramRData(ramRData), .tok(tok_bus), .keyPadClear(keyPadClear), .busy(busy),
    .tokenCount(tokenCount), .overflow(overflow), .dropErr(dropErr)
  );

  always #5 clk = ~clk;

  // token RAM: single port, registered read
  logic [TOKEN_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ramWe) mem[ramAddr] <= ramWData;
    ramRData <= mem[ramAddr];
  end

  // reference model: buffered tokens and sticky flags
  logic [TOKEN_W-1:0] q[$];
  bit m_ovf, m_drop;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_write(input logic [TOKEN_W-1:0] t);
    if (q.size() < DEPTH) q.push_back(t);
    else m_ovf = 1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tokOut"}, tok_bus.tokOut, 0);
    chk({tag, "_tokValid"}, tok_bus.tokValid, 0);
    chk({tag, "_tokLast"}, tok_bus.tokLast, 0);
    chk({tag, "_kpc"}, keyPadClear, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_count"}, tokenCount, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_drop"}, dropErr, 0);
    chk({tag, "_ram"}, {ramAddr, ramWe, ramWData}, 0);
  endtask

  task automatic write_tok(input logic [TOKEN_W-1:0] t);
    wEn = 1; tokenToWrite = t;
    #1;
    chk("ram_we", ramWe, q.size() < DEPTH);
    if (q.size() < DEPTH) begin
      chk("ram_addr", ramAddr, q.size());
      chk("ram_wdata", ramWData, t);
    end
    m_write(t);
    @(negedge clk);
    wEn = 0;
    chk("wr_count", tokenCount, q.size());
    chk("wr_ovf", overflow, m_ovf);
    chk("wr_drop", dropErr, m_drop);
  endtask

  // mode 0: always ready, 1: stall 5 cycles on token 4, 2: random ready
  task automatic stream(input int mode, input bit with_wr, input bit inject);
    logic [TOKEN_W-1:0] exp[$];
    logic [TOKEN_W-1:0] prev_tok;
    bit prev_v, prev_hs, prev_last, done, rdy, injected, inj_chk;
    int idx, c, last_hs, nxt_valid, stall;
    enterKey = 1;
    if (with_wr) begin
      wEn = 1; tokenToWrite = $urandom; m_write(tokenToWrite);
    end
    exp = q;
    @(negedge clk);
    enterKey = 0; wEn = 0;
    c = 1; idx = 0; nxt_valid = 3; stall = 0; last_hs = 0;
    done = 0; prev_v = 0; prev_hs = 0; prev_last = 0; prev_tok = '0;
    injected = 0; inj_chk = 0;
    while (!done && c < 3000) begin
      wEn = 0;
      tokReady_drv(0);
      if (inj_chk) begin
        chk("inj_drop", dropErr, 1);
        chk("inj_count", tokenCount, exp.size());
        inj_chk = 0;
      end
      if (keyPadClear) begin
        chk("kpc_time", c, (exp.size() == 0) ? 1 : last_hs + 1);
        chk("kpc_all", idx, exp.size());
        chk("kpc_busy", busy, 1);
        done = 1;
      end else begin
        chk("busy", busy, 1);
        if (prev_hs) chk("valid_drop", tok_bus.tokValid, 0);
        rdy = 0;
        if (tok_bus.tokValid) begin
          if (!prev_v) chk("valid_lat", c, nxt_valid);
          else begin
            chk("hold_tok", tok_bus.tokOut, prev_tok);
            chk("hold_last", tok_bus.tokLast, prev_last);
          end
          case (mode)
            0: rdy = 1;
            1: if (idx == 4 && stall < 5) begin rdy = 0; stall++; end else rdy = 1;
            default: rdy = ($urandom_range(0, 1) == 1);
          endcase
          if (inject && !injected && idx == 1) begin
            wEn = 1; tokenToWrite = $urandom; m_drop = 1;
            injected = 1; inj_chk = 1;
          end
          if (rdy) begin
            chk("tok", tok_bus.tokOut, exp[idx]);
            chk("last", tok_bus.tokLast, idx == exp.size() - 1);
            idx++; last_hs = c; nxt_valid = c + 3;
          end
        end
        prev_v = tok_bus.tokValid; prev_hs = tok_bus.tokValid && rdy;
        prev_tok = tok_bus.tokOut; prev_last = tok_bus.tokLast;
        tokReady_drv(rdy);
        @(negedge clk);
        c++;
      end
    end
    wEn = 0; tokReady_drv(0);
    if (!done) chk("timeout", 0, 1);
    q.delete(); m_ovf = 0;
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_count", tokenCount, 0);
    chk("post_ovf", overflow, 0);
    chk("post_drop", dropErr, m_drop);
    chk("post_kpc", keyPadClear, 0);
  endtask

  task automatic tokReady_drv(input bit v);
    tok_bus.tokReady = v;
  endtask

  initial begin
    int n, w;
    resetN = 0; wEn = 0; enterKey = 0; tokenToWrite = '0; tok_bus.tokReady = 0;
    m_ovf = 0; m_drop = 0;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    resetN = 1;
    @(negedge clk);

    // fixed 10-token stream, always ready
    for (int i = 0; i < 10; i++) write_tok(32'h11 + i);
    stream(0, 0, 0);
    // same stream with a 5-cycle stall on token 4
    for (int i = 0; i < 10; i++) write_tok(32'h11 + i);
    stream(1, 0, 0);
    // empty buffer
    stream(0, 0, 0);
    // overflow: 65 writes into 64 slots
    for (int i = 0; i < 65; i++) write_tok($urandom);
    chk("ovf_set", overflow, 1);
    stream(2, 0, 0);
    // write dropped while streaming, then an unaffected stream
    for (int i = 0; i < 6; i++) write_tok($urandom);
    stream(0, 0, 1);
    for (int i = 0; i < 4; i++) write_tok($urandom);
    stream(2, 0, 0);
    // write and enter in the same cycle
    for (int i = 0; i < 2; i++) write_tok($urandom);
    stream(0, 1, 0);

    // reset in the middle of a stream
    for (int i = 0; i < 5; i++) write_tok($urandom);
    enterKey = 1;
    @(negedge clk);
    enterKey = 0;
    w = 0;
    while (!tok_bus.tokValid && w < 20) begin @(negedge clk); w++; end
    chk("mid_valid_seen", tok_bus.tokValid, 1);
    resetN = 0;
    @(negedge clk);
    chk_zero("mid_rst");
    resetN = 1;
    q.delete(); m_ovf = 0; m_drop = 0;
    @(negedge clk);
    chk("mid_kpc", keyPadClear, 0);
    for (int i = 0; i < 3; i++) write_tok($urandom);
    stream(2, 0, 0);

    // random rounds
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) write_tok($urandom);
      stream(2, $urandom_range(0, 1) == 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
